mc_main_fsm: RTL and testbench

Main control state machine for the multicycle ARM processor. It sequences every instruction through fetch, decode, execute, memory and writeback steps, driving the datapath multiplexer selects and the enables that the top level turns into `MemWrite`, register writes and PC updates. It sits in the controller between the instruction decoder inputs (`Op`, `Funct`) and the condition logic that gates `RegW`, `MemW` and `NextPC`. Outputs are Moore-style, decoded from the registered state only.

---
 rtl/mc_main_fsm.sv | 125 ++++++++++++
 tb/tb_mc_main_fsm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle ARM core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives Moore-decoded datapath controls.
module mc_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        TRAP   = 4'd10
    } state_e;

    state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values; reset is synchronous and checked first.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every output and state_d gets a default before the case, so no
    // path through this block can infer a latch.
    always_comb begin
        state_d   = TRAP;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;

        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_d = FETCH;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                state_d   = FETCH;
            end
            // TRAP and any unused encoding park in TRAP until reset.
            default: begin
                Illegal = 1'b1;
                state_d = TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm: expected per-cycle controls come from a
// step table and an instruction-class sequence model; Op/Funct are random in don't-care cycles.
module tb_mc_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0] ALUSrcB, ResultSrc;

    int vectors = 0;
    int fails   = 0;

    mc_main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP} step_e;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal}
    logic [12:0] obs;
    assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal};

    function automatic logic [12:0] step_out(input step_e s);
        case (s)
            S_FETCH:  return {1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            S_DECODE: return {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_MEMADR: return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_MEMRD:  return {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_MEMWB:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            S_MEMWR:  return {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            S_EXECR:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_EXECI:  return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_ALUWB:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            S_BRANCH: return {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            default:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        endcase
    endfunction

    // Instruction-level model: the whole step sequence follows from the instruction class.
    task automatic build_seq(input logic [1:0] op, input logic [5:0] funct, output step_e seq[$]);
        seq = {};
        case (op)
            2'b01:   seq = funct[0] ? '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB}
                                    : '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
            2'b00:   seq = '{S_FETCH, S_DECODE, funct[5] ? S_EXECI : S_EXECR, S_ALUWB};
            2'b10:   seq = '{S_FETCH, S_DECODE, S_BRANCH};
            default: seq = '{S_FETCH, S_DECODE, S_TRAP};
        endcase
    endtask

    task automatic check(input string tag, input step_e s);
        logic [12:0] exp;
        exp = step_out(s);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s step=%s observed=%b expected=%b", tag, s.name(), obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from step index `start`; Op/Funct carry the instruction only
    // while the FSM may look at them, random otherwise.
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                             input int start, input int expect_len);
        step_e seq[$];
        build_seq(op, funct, seq);
        vectors++;
        assert (seq.size() == expect_len) else begin
            fails++;
            $error("FAIL %s_cpi model_len=%0d expected=%0d", tag, seq.size(), expect_len);
        end
        for (int i = start; i < seq.size(); i++) begin
            if (seq[i] == S_DECODE || seq[i] == S_MEMADR) begin
                Op = op; Funct = funct;
            end else begin
                Op = 2'($urandom); Funct = 6'($urandom);
            end
            check(tag, seq[i]);
            if (seq[i] != S_TRAP) next_edge();
        end
    endtask

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        int len;

        reset = 1'b1; Op = 2'($urandom); Funct = 6'($urandom);
        next_edge();
        check("reset_1", S_FETCH);
        Op = 2'($urandom); Funct = 6'($urandom);
        next_edge();
        check("reset_2", S_FETCH);

        reset = 1'b0; Op = 2'b00; Funct = 6'b001000;
        next_edge();
        check("reset_release", S_DECODE);
        run_instr("first_add", 2'b00, 6'b001000, 1, 4);

        run_instr("ldr", 2'b01, 6'b011001, 0, 5);
        run_instr("str", 2'b01, 6'b011000, 0, 4);
        run_instr("add_reg", 2'b00, 6'b001000, 0, 4);
        run_instr("orr_imm", 2'b00, 6'b111000, 0, 4);
        run_instr("branch", 2'b10, 6'($urandom), 0, 3);
        check("after_branch", S_FETCH);

        // Illegal opcode parks in TRAP regardless of inputs until reset.
        run_instr("illegal", 2'b11, 6'($urandom), 0, 3);
        for (int i = 0; i < 10; i++) begin
            next_edge();
            Op = 2'($urandom); Funct = 6'($urandom);
            check("trap_hold", S_TRAP);
        end
        reset = 1'b1;
        next_edge();
        check("trap_reset", S_FETCH);
        reset = 1'b0;

        // Reset asserted in MEMADR of an STR aborts it before MEMWR.
        Op = 2'($urandom); Funct = 6'($urandom);
        check("abort_fetch", S_FETCH);
        next_edge();
        Op = 2'b01; Funct = 6'b011000;
        check("abort_decode", S_DECODE);
        next_edge();
        reset = 1'b1;
        check("abort_memadr", S_MEMADR);
        next_edge();
        check("abort_reset", S_FETCH);
        reset = 1'b0;

        // Random legal instructions back to back.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       op = 2'b00;
                1:       op = 2'b01;
                default: op = 2'b10;
            endcase
            fn = 6'($urandom);
            if (op == 2'b01)      len = fn[0] ? 5 : 4;
            else if (op == 2'b00) len = 4;
            else                  len = 3;
            run_instr("random", op, fn, 0, len);
        end
        check("final_fetch", S_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
